// File: rtl/pc_irq_unit_pkg.sv
// Shared encodings and default vector constants for the PC / interrupt unit.
package pc_irq_unit_pkg;

    // Next-PC source selector encodings
    localparam logic [2:0] PCS_SEQ  = 3'd0;
    localparam logic [2:0] PCS_BR   = 3'd1;
    localparam logic [2:0] PCS_J    = 3'd2;
    localparam logic [2:0] PCS_JR   = 3'd3;
    localparam logic [2:0] PCS_ERET = 3'd4;

    // Exception cause: 0 is illegal-op, k+1 is IRQ channel k
    localparam logic [3:0] CAUSE_ILLOP = 4'd0;

    // Default vector layout
    localparam logic [31:0] DEF_RESET_VEC  = 32'h8000_0000;
    localparam logic [31:0] DEF_VEC_BASE   = 32'h8000_0004;
    localparam int unsigned DEF_VEC_STRIDE = 4;

    // Vector address of IRQ channel idx: base + (idx+1)*stride
    function automatic logic [31:0] irq_vector(input logic [31:0] base,
                                               input int unsigned stride,
                                               input logic [3:0]  idx);
        return base + ((32'(idx) + 32'd1) * stride);
    endfunction

endpackage

// File: rtl/pc_irq_unit_irq_sync_edge.sv
// One interrupt channel: two-flop synchroniser followed by a rising-edge
// detector. Runs on every clock, independent of the core step enable.
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic irq_async,
    output logic rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // Synchronise the asynchronous request and remember the previous level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= irq_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/pc_irq_unit.sv
// Program counter, next-PC selection, illegal-op exception and fixed-priority
// interrupt vectoring with EPC save/restore. State advances on the step enable.
module pc_irq_unit
    import pc_irq_unit_pkg::*;
#(
    parameter int unsigned NIRQ       = 2,
    parameter logic [31:0] RESET_VEC  = DEF_RESET_VEC,
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            stall,
    input  logic [2:0]      pc_src,
    input  logic            branch_taken,
    input  logic [15:0]     branch_imm,
    input  logic [25:0]     jump_idx,
    input  logic [31:0]     jr_target,
    input  logic            illop,
    input  logic [NIRQ-1:0] irq_in,
    input  logic [NIRQ-1:0] irq_mask,
    output logic [31:0]     pc,
    output logic [31:0]     pc_plus_4,
    output logic            exc_take,
    output logic [3:0]      exc_cause,
    output logic [31:0]     epc,
    output logic [NIRQ-1:0] pending
);

    logic [31:0]     r_pc;
    logic [31:0]     r_epc;
    logic [NIRQ-1:0] r_pending;

    logic [NIRQ-1:0] w_rise;
    logic [NIRQ-1:0] w_req;
    logic [NIRQ-1:0] w_clr;
    logic [31:0]     w_pc_plus_4;
    logic [30:0]     w_br_off;
    logic [31:0]     w_br_target;
    logic [31:0]     w_j_target;
    logic [31:0]     w_eret_target;
    logic [31:0]     w_seq_next;
    logic [31:0]     w_next_pc;
    logic            w_step;
    logic            w_irq_hit;
    logic            w_take_irq;
    logic            w_exc_take;
    logic [3:0]      w_irq_idx;

    for (genvar g = 0; g < NIRQ; g++) begin : g_irq
        irq_sync_edge u_sync (
            .clk       (clk),
            .reset     (reset),
            .irq_async (irq_in[g]),
            .rise      (w_rise[g])
        );
    end

    // PC arithmetic on bits [30:0] only; bit 31 (kernel mode) is carried over
    assign w_pc_plus_4   = {r_pc[31], r_pc[30:0] + 31'd4};
    assign w_br_off      = {{13{branch_imm[15]}}, branch_imm, 2'b00};
    assign w_br_target   = {w_pc_plus_4[31], w_pc_plus_4[30:0] + w_br_off};
    assign w_j_target    = {w_pc_plus_4[31:28], jump_idx, 2'b00};
    assign w_eret_target = {1'b0, r_epc[30:0]};

    assign w_step     = en & ~stall;
    assign w_req      = r_pending & irq_mask;
    assign w_irq_hit  = ~r_pc[31] & (|w_req);
    assign w_take_irq = w_step & ~illop & w_irq_hit;
    assign w_exc_take = w_step & (illop | w_irq_hit);

    // Fixed priority: lowest-numbered enabled pending channel wins
    always_comb begin
        logic w_found;
        w_found   = 1'b0;
        w_irq_idx = '0;
        for (int unsigned k = 0; k < NIRQ; k++) begin
            if (w_req[k] && !w_found) begin
                w_found   = 1'b1;
                w_irq_idx = 4'(k);
            end
        end
    end

    // One-hot clear of the channel being taken this step
    always_comb begin
        w_clr = '0;
        for (int unsigned k = 0; k < NIRQ; k++) begin
            w_clr[k] = w_take_irq && (w_irq_idx == 4'(k));
        end
    end

    // Normal next-PC selection by pc_src
    always_comb begin
        w_seq_next = w_pc_plus_4;
        case (pc_src)
            PCS_SEQ:  w_seq_next = w_pc_plus_4;
            PCS_BR:   w_seq_next = branch_taken ? w_br_target : w_pc_plus_4;
            PCS_J:    w_seq_next = w_j_target;
            PCS_JR:   w_seq_next = jr_target;
            PCS_ERET: w_seq_next = w_eret_target;
            default:  w_seq_next = w_pc_plus_4;
        endcase
    end

    // Exception priority: illegal-op, then IRQ (user mode only), then normal flow
    always_comb begin
        if (illop) begin
            w_next_pc = VEC_BASE;
        end else if (w_irq_hit) begin
            w_next_pc = irq_vector(VEC_BASE, VEC_STRIDE, w_irq_idx);
        end else begin
            w_next_pc = w_seq_next;
        end
    end

    // PC and EPC commit on a non-stalled enabled step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= RESET_VEC;
            r_epc <= '0;
        end else if (w_step) begin
            r_pc <= w_next_pc;
            if (w_exc_take) begin
                r_epc <= r_pc;
            end
        end
    end

    // Pending capture runs every clock so edges are never lost; a new edge
    // on the channel being cleared keeps it pending
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    assign pc        = r_pc;
    assign pc_plus_4 = w_pc_plus_4;
    assign epc       = r_epc;
    assign pending   = r_pending;
    assign exc_take  = w_exc_take;
    assign exc_cause = w_take_irq ? (w_irq_idx + 4'd1) : CAUSE_ILLOP;

endmodule

// File: tb/tb_pc_irq_unit.sv
// Scoreboard bench for pc_irq_unit: directed stimulus pushes expected
// observations; a negedge monitor pops and compares them.
module tb_pc_irq_unit;

    localparam logic [3:0] M_PC   = 4'b0001;
    localparam logic [3:0] M_EPC  = 4'b0010;
    localparam logic [3:0] M_PEND = 4'b0100;
    localparam logic [3:0] M_EXC  = 4'b1000;
    localparam logic [3:0] M_ALL  = 4'b1111;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [1:0]  pend;
        logic        take;
        logic [3:0]  cause;
        logic [3:0]  mask;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        en;
    logic        stall;
    logic [2:0]  pc_src;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic [25:0] jump_idx;
    logic [31:0] jr_target;
    logic        illop;
    logic [1:0]  irq_in;
    logic [1:0]  irq_mask;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        exc_take;
    logic [3:0]  exc_cause;
    logic [31:0] epc;
    logic [1:0]  pending;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pc_irq_unit #(
        .NIRQ       (2),
        .RESET_VEC  (32'h8000_0000),
        .VEC_BASE   (32'h8000_0004),
        .VEC_STRIDE (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .stall        (stall),
        .pc_src       (pc_src),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump_idx     (jump_idx),
        .jr_target    (jr_target),
        .illop        (illop),
        .irq_in       (irq_in),
        .irq_mask     (irq_mask),
        .pc           (pc),
        .pc_plus_4    (pc_plus_4),
        .exc_take     (exc_take),
        .exc_cause    (exc_cause),
        .epc          (epc),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: one expectation checked per falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.mask[0]) cmp(e.name, "pc", pc, e.pc);
                if (e.mask[1]) cmp(e.name, "epc", epc, e.epc);
                if (e.mask[2]) cmp(e.name, "pending", {30'd0, pending}, {30'd0, e.pend});
                if (e.mask[3]) begin
                    cmp(e.name, "exc_take", {31'd0, exc_take}, {31'd0, e.take});
                    cmp(e.name, "exc_cause", {28'd0, exc_cause}, {28'd0, e.cause});
                end
            end
        end
    end

    task automatic expect_obs(input string nm, input logic [31:0] p, input logic [31:0] ep,
                              input logic [1:0] pd, input logic tk, input logic [3:0] cs,
                              input logic [3:0] m);
        exp_t e;
        e.name = nm; e.pc = p; e.epc = ep; e.pend = pd;
        e.take = tk; e.cause = cs; e.mask = m;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_jr(input logic [31:0] t);
        pc_src    = 3'd3;
        jr_target = t;
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; stall = 1'b0; pc_src = 3'd0;
        branch_taken = 1'b0; branch_imm = '0; jump_idx = '0; jr_target = '0;
        illop = 1'b0; irq_in = '0; irq_mask = '0;

        // Reset held while clock toggles
        repeat (3) cyc();
        expect_obs("reset", 32'h8000_0000, 32'h0, 2'b00, 1'b0, 4'd0, M_ALL);
        reset = 1'b1;
        cyc(); expect_obs("seq1", 32'h8000_0004, 32'h0, 2'b00, 1'b0, 4'd0, M_PC | M_EXC);
        cyc(); expect_obs("seq2", 32'h8000_0008, 32'h0, 2'b00, 1'b0, 4'd0, M_PC);

        // Branch / jump arithmetic
        set_jr(32'h0000_0100);
        cyc(); expect_obs("jr100", 32'h0000_0100, 32'h0, 2'b00, 1'b0, 4'd0, M_PC);
        pc_src = 3'd1; branch_taken = 1'b1; branch_imm = 16'hFFFF;
        cyc(); expect_obs("br_back", 32'h0000_0100, 32'h0, 2'b00, 1'b0, 4'd0, M_PC);
        branch_taken = 1'b0;
        cyc(); expect_obs("br_not", 32'h0000_0104, 32'h0, 2'b00, 1'b0, 4'd0, M_PC);
        branch_taken = 1'b1; branch_imm = 16'h0010;
        cyc(); expect_obs("br_fwd", 32'h0000_0148, 32'h0, 2'b00, 1'b0, 4'd0, M_PC);
        set_jr(32'h8000_0100);
        cyc(); expect_obs("jr_k", 32'h8000_0100, 32'h0, 2'b00, 1'b0, 4'd0, M_PC);
        pc_src = 3'd2; jump_idx = 26'h40;
        cyc(); expect_obs("jump", 32'h8000_0100, 32'h0, 2'b00, 1'b0, 4'd0, M_PC);
        pc_src = 3'd1; branch_imm = 16'h8000;
        cyc(); expect_obs("br_wrap", 32'hFFFE_0104, 32'h0, 2'b00, 1'b0, 4'd0, M_PC);
        set_jr(32'hFFFF_FFFC);
        cyc(); expect_obs("jr_top", 32'hFFFF_FFFC, 32'h0, 2'b00, 1'b0, 4'd0, M_PC);
        pc_src = 3'd7;
        cyc(); expect_obs("seq_wrap", 32'h8000_0000, 32'h0, 2'b00, 1'b0, 4'd0, M_PC);

        // IRQ vectoring from user mode
        set_jr(32'h0000_0200);
        cyc(); expect_obs("jr200", 32'h0000_0200, 32'h0, 2'b00, 1'b0, 4'd0, M_PC);
        irq_mask = 2'b11; irq_in = 2'b11;
        cyc(); expect_obs("sync1", 32'h0000_0200, 32'h0, 2'b00, 1'b0, 4'd0, M_PC | M_PEND | M_EXC);
        irq_in = 2'b00;
        cyc(); expect_obs("sync2", 32'h0000_0200, 32'h0, 2'b00, 1'b0, 4'd0, M_PEND | M_EXC);
        cyc(); expect_obs("irq0_req", 32'h0000_0200, 32'h0, 2'b11, 1'b1, 4'd1, M_PC | M_PEND | M_EXC);
        cyc(); pc_src = 3'd0;
        expect_obs("irq0_taken", 32'h8000_0008, 32'h0000_0200, 2'b10, 1'b0, 4'd0, M_ALL);
        cyc(); expect_obs("kern_hold", 32'h8000_000C, 32'h0000_0200, 2'b10, 1'b0, 4'd0, M_ALL);
        pc_src = 3'd4;
        cyc(); pc_src = 3'd0;
        expect_obs("eret_irq1", 32'h0000_0200, 32'h0000_0200, 2'b10, 1'b1, 4'd2, M_ALL);
        cyc(); expect_obs("irq1_taken", 32'h8000_000C, 32'h0000_0200, 2'b00, 1'b0, 4'd0, M_ALL);

        // Masked accumulation, then illop beats a pending IRQ
        set_jr(32'h0000_0300); irq_mask = 2'b00; irq_in = 2'b01;
        cyc(); irq_in = 2'b00;
        expect_obs("jr300", 32'h0000_0300, 32'h0000_0200, 2'b00, 1'b0, 4'd0, M_PC | M_EXC);
        cyc();
        cyc(); expect_obs("masked_acc", 32'h0000_0300, 32'h0000_0200, 2'b01, 1'b0, 4'd0, M_ALL);
        cyc(); irq_mask = 2'b01; illop = 1'b1;
        expect_obs("illop_req", 32'h0000_0300, 32'h0000_0200, 2'b01, 1'b1, 4'd0, M_ALL);
        cyc(); pc_src = 3'd0;
        expect_obs("illop_kern", 32'h8000_0004, 32'h0000_0300, 2'b01, 1'b1, 4'd0, M_ALL);
        cyc(); illop = 1'b0; pc_src = 3'd4;
        expect_obs("illop_k_tk", 32'h8000_0004, 32'h8000_0004, 2'b01, 1'b0, 4'd0, M_ALL);
        cyc(); pc_src = 3'd0;
        expect_obs("eret_clr31", 32'h0000_0004, 32'h8000_0004, 2'b01, 1'b1, 4'd1, M_ALL);
        cyc(); en = 1'b0; irq_in = 2'b10;
        expect_obs("irq0_late", 32'h8000_0008, 32'h0000_0004, 2'b00, 1'b0, 4'd0, M_ALL);

        // en=0 freezes state, edges still captured
        cyc(); irq_in = 2'b00;
        repeat (9) cyc();
        expect_obs("en0_freeze", 32'h8000_0008, 32'h0000_0004, 2'b10, 1'b0, 4'd0, M_ALL);
        en = 1'b1; irq_mask = 2'b00; set_jr(32'h0000_0400);

        // Stall holds PC and blocks exception; clear/set on different channels
        cyc(); stall = 1'b1; irq_mask = 2'b11; pc_src = 3'd0;
        expect_obs("stall_a", 32'h0000_0400, 32'h0000_0004, 2'b10, 1'b0, 4'd0, M_ALL);
        cyc(); irq_in = 2'b01;
        expect_obs("stall_b", 32'h0000_0400, 32'h0000_0004, 2'b10, 1'b0, 4'd0, M_PC | M_EXC);
        cyc(); irq_in = 2'b00;
        expect_obs("stall_c", 32'h0000_0400, 32'h0000_0004, 2'b10, 1'b0, 4'd0, M_PC | M_PEND | M_EXC);
        cyc(); stall = 1'b0;
        expect_obs("unstall", 32'h0000_0400, 32'h0000_0004, 2'b10, 1'b1, 4'd2, M_ALL);
        cyc(); irq_in = 2'b01; pc_src = 3'd4; irq_mask = 2'b00;
        expect_obs("clr1_set0", 32'h8000_000C, 32'h0000_0400, 2'b01, 1'b0, 4'd0, M_ALL);

        // Same-channel clear and new edge: set wins
        cyc(); stall = 1'b1; irq_mask = 2'b01; irq_in = 2'b00;
        expect_obs("sw_a", 32'h0000_0400, 32'h0000_0400, 2'b01, 1'b0, 4'd0, M_ALL);
        cyc(); stall = 1'b0;
        expect_obs("sw_b", 32'h0000_0400, 32'h0000_0400, 2'b01, 1'b1, 4'd1, M_ALL);
        cyc(); pc_src = 3'd0;
        expect_obs("set_wins", 32'h8000_0008, 32'h0000_0400, 2'b01, 1'b0, 4'd0, M_ALL);

        // Asynchronous reset between edges
        cyc(); #2; reset = 1'b0; #1;
        expect_obs("async_rst", 32'h8000_0000, 32'h0, 2'b00, 1'b0, 4'd0, M_ALL);
        cyc(); reset = 1'b1;
        cyc(); expect_obs("post_rst", 32'h8000_0004, 32'h0, 2'b00, 1'b0, 4'd0, M_PC | M_EPC | M_PEND);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_irq_unit.md
Name: pc_irq_unit

Overview:
- Parametrised program-counter and interrupt-vectoring unit for the MIPS core.
- Owns the PC register, next-PC selection (sequential / branch / jump / jr / eret), and NIRQ interrupt channels with synchronisation, edge capture, masking and fixed priority.
- Owns the illegal-op exception vector and the EPC save/restore.
- Is advanced by a clock enable rather than a divided clock, so the core runs on the system clock.

Parameters:
- NIRQ, 2, number of interrupt channels (1..8).
- RESET_VEC, 32'h8000_0000, PC value after reset.
- VEC_BASE, 32'h8000_0004, illegal-op vector; IRQ k vectors to VEC_BASE + (k+1)*VEC_STRIDE.
- VEC_STRIDE, 4, byte spacing between vectors.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  core step enable; all state except the IRQ synchronisers updates only when en=1.
- stall  in  1  hold PC; only meaningful when en=1.
- pc_src  in  3  0=+4, 1=branch, 2=jump, 3=jr, 4=eret.
- branch_taken  in  1  branch condition result.
- branch_imm  in  16  signed word offset.
- jump_idx  in  26  jump instr_index.
- jr_target  in  32  register operand for jr.
- illop  in  1  decode flagged an illegal instruction.
- irq_in  in  NIRQ  asynchronous level requests from peripherals.
- irq_mask  in  NIRQ  1=channel enabled.
- pc  out  32  current PC.
- pc_plus_4  out  32  {pc[31], pc[30:0]+4}.
- exc_take  out  1  exception/IRQ accepted this step; the core writes pc to $26 and suppresses side effects.
- exc_cause  out  4  0=illop, k+1=IRQ k.
- epc  out  32  saved PC.
- pending  out  NIRQ  captured, not-yet-taken IRQs.

Behaviour:
- Reset (async, reset=0) state:
  - pc=RESET_VEC, epc=0.
  - pending=0.
  - synchroniser flops=0.
  - exc_take=0, exc_cause=0.
- Synchroniser: two flops per channel, clocked every clk regardless of en.
- Edge capture: pending[k] sets on a synchronised rising edge. The edge detector's previous-value flop also updates every clk, so edges arriving while en=0 are not lost.
- Kernel mode: pc[31]=1. No IRQ is taken in kernel mode; pending bits are held.
- Arithmetic:
  - pc[31] is never changed by +4, branch or jump.
  - Branch target = pc_plus_4 + sign_ext(branch_imm)<<2 on bits [30:0]; bit 31 is kept. If branch_taken=0, next = pc_plus_4.
  - Jump target = {pc_plus_4[31:28], jump_idx, 2'b00}.
  - jr target is jr_target verbatim. This is the only way, besides reset, to clear pc[31] other than eret.
  - eret: next = epc with bit 31 cleared.
- Step decision, evaluated combinationally and committed only on en=1 && stall=0, in priority order:
  1. illop=1 → exc_cause=0, next=VEC_BASE. The illop exception is taken even in kernel mode.
  2. Otherwise, if pc[31]=0 and any (pending & irq_mask) → pick the lowest set index k; exc_cause=k+1; next=VEC_BASE+(k+1)*VEC_STRIDE; clear pending[k] in the same step.
  3. Otherwise, normal pc_src selection. Undefined pc_src (5..7) → pc_plus_4.
- On a taken exception or IRQ: epc <= pc, so the interrupted instruction re-executes after eret.
- exc_take is combinational. It is 1 only when en=1, stall=0 and case 1 or case 2 holds.
- stall=1 or en=0: pc, epc and pending are unchanged, except that new edges still set pending. A new edge setting pending[j] in the same step that clears pending[k] (j≠k) is allowed; both updates apply.
- Same-channel simultaneous clear and new edge: set wins, so the request stays pending.
- Masked channels accumulate pending. Taking the IRQ later, once unmasked, is permitted.
- Reset asserted mid-step overrides everything.

Decomposition:
- Shared package holds:
  - the pc_src encodings (PCS_SEQ, PCS_BR, PCS_J, PCS_JR, PCS_ERET);
  - the cause encoding (CAUSE_ILLOP);
  - the default vector constants.
- One sub-module, irq_sync_edge: two-flop synchroniser plus rising-edge detector for one channel. It is instantiated NIRQ times via generate.

Test Plan:
- Reset: hold reset=0, toggle clk → pc=32'h8000_0000, pending=0. Release reset, en=1 always, pc_src=0 → pc=8000_0004, then 8000_0008.
- Branch and jump: pc=0000_0100, pc_src=1, branch_taken=1, branch_imm=16'hFFFF → pc=0000_0100; from 8000_0100, pc_src=2, jump_idx=26'h40 → pc=8000_0100.
- IRQ vectoring: pc=0000_0200, irq_mask=2'b11, irq_in=2'b11 pulsed high:
  - 3 clk later, step → exc_take=1, exc_cause=1, pc=8000_0008, epc=0000_0200, pending=2'b10;
  - no IRQ is taken while pc[31]=1;
  - pc_src=4 → pc=0000_0200, next step takes IRQ1 → pc=8000_000C.
- Illop priority: pending IRQ0 and illop=1 at pc=0000_0300 → exc_cause=0, pc=8000_0004, pending IRQ0 retained.
- Enable and stall: en=0 for 10 clk with an irq_in edge → pc frozen, pending set; stall=1 with en=1 → pc frozen, exc_take=0.
- Async reset mid-run: assert reset between clk edges → pc immediately 8000_0000, epc=0, pending=0.
